// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
// Shares the single CPU system-bus master port between the instruction-fetch
// requester (port I) and the data-cache requester (port D). One requester owns
// the bus per transaction. Ties are broken round-robin against the last port
// that completed a transfer. A saturating counter records arbitration cycles
// in which both ports were requesting.
// State, last_grant and the contention counter are registered. Bus and ready
// outputs are decoded combinationally from the state, so the bus ready strobe
// reaches the owner with no added latency.

module cpu_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  // port I (instruction fetch)
  input  logic              i_i_request,
  input  logic              i_i_rw,
  input  logic [ADDR_W-1:0] i_i_address,
  input  logic [DATA_W-1:0] i_i_wdata,
  output logic              o_i_ready,
  output logic [DATA_W-1:0] o_i_rdata,
  // port D (data cache)
  input  logic              i_d_request,
  input  logic              i_d_rw,
  input  logic [ADDR_W-1:0] i_d_address,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ready,
  output logic [DATA_W-1:0] o_d_rdata,
  // external bus
  output logic              o_bus_request,
  output logic              o_bus_rw,
  output logic [ADDR_W-1:0] o_bus_address,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ready,
  input  logic [DATA_W-1:0] i_bus_rdata,
  // status
  output logic [1:0]        o_grant,
  output logic [CNT_W-1:0]  o_contention
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_t;

  // Encoding of the port that last completed a transfer.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] contention_q, contention_d;

  // State, round-robin pointer and contention counter; last_grant resets to D
  // so that port I wins the first tie.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_D;
      contention_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      contention_q <= contention_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, leave a grant on ready or on abort.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    contention_d = contention_q;
    case (state_q)
      ST_IDLE: begin
        if (i_i_request && i_d_request) begin
          if (contention_q != CNT_MAX) begin
            contention_d = contention_q + CNT_ONE;
          end else begin
            contention_d = contention_q;
          end
          if (last_grant_q == LAST_D) begin
            state_d = ST_GRANT_I;
          end else begin
            state_d = ST_GRANT_D;
          end
        end else if (i_i_request) begin
          state_d = ST_GRANT_I;
        end else if (i_d_request) begin
          state_d = ST_GRANT_D;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT_I: begin
        if (i_bus_ready) begin
          last_grant_d = LAST_I;
          state_d      = ST_IDLE;
        end else if (!i_i_request) begin
          // Abort: the pointer only advances on a completed transfer.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANT_I;
        end
      end
      ST_GRANT_D: begin
        if (i_bus_ready) begin
          last_grant_d = LAST_D;
          state_d      = ST_IDLE;
        end else if (!i_d_request) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANT_D;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: route the owner's request to the bus and the bus ready/rdata
  // back to the owner only; everything is zero while idle.
  always_comb begin
    o_bus_request = 1'b0;
    o_bus_rw      = 1'b0;
    o_bus_address = {ADDR_W{1'b0}};
    o_bus_wdata   = {DATA_W{1'b0}};
    o_i_ready     = 1'b0;
    o_i_rdata     = {DATA_W{1'b0}};
    o_d_ready     = 1'b0;
    o_d_rdata     = {DATA_W{1'b0}};
    o_grant       = 2'b00;
    case (state_q)
      ST_GRANT_I: begin
        o_bus_request = 1'b1;
        o_bus_rw      = i_i_rw;
        o_bus_address = i_i_address;
        o_bus_wdata   = i_i_wdata;
        o_i_ready     = i_bus_ready;
        o_i_rdata     = i_bus_rdata;
        o_grant       = 2'b01;
      end
      ST_GRANT_D: begin
        o_bus_request = 1'b1;
        o_bus_rw      = i_d_rw;
        o_bus_address = i_d_address;
        o_bus_wdata   = i_d_wdata;
        o_d_ready     = i_bus_ready;
        o_d_rdata     = i_bus_rdata;
        o_grant       = 2'b10;
      end
      default: begin
        o_grant = 2'b00;
      end
    endcase
  end

  assign o_contention = contention_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter
// Directed-vector bench for cpu_bus_arbiter. Inputs are driven 2 time units
// after the rising edge and outputs are sampled 1 unit later, well before the
// falling edge.

module tb_cpu_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;

  logic              i_clock;
  logic              i_reset;
  logic              i_i_request;
  logic              i_i_rw;
  logic [ADDR_W-1:0] i_i_address;
  logic [DATA_W-1:0] i_i_wdata;
  logic              o_i_ready;
  logic [DATA_W-1:0] o_i_rdata;
  logic              i_d_request;
  logic              i_d_rw;
  logic [ADDR_W-1:0] i_d_address;
  logic [DATA_W-1:0] i_d_wdata;
  logic              o_d_ready;
  logic [DATA_W-1:0] o_d_rdata;
  logic              o_bus_request;
  logic              o_bus_rw;
  logic [ADDR_W-1:0] o_bus_address;
  logic [DATA_W-1:0] o_bus_wdata;
  logic              i_bus_ready;
  logic [DATA_W-1:0] i_bus_rdata;
  logic [1:0]        o_grant;
  logic [CNT_W-1:0]  o_contention;

  int n_vec;
  int n_err;

  cpu_bus_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_i_request  (i_i_request),
    .i_i_rw       (i_i_rw),
    .i_i_address  (i_i_address),
    .i_i_wdata    (i_i_wdata),
    .o_i_ready    (o_i_ready),
    .o_i_rdata    (o_i_rdata),
    .i_d_request  (i_d_request),
    .i_d_rw       (i_d_rw),
    .i_d_address  (i_d_address),
    .i_d_wdata    (i_d_wdata),
    .o_d_ready    (o_d_ready),
    .o_d_rdata    (o_d_rdata),
    .o_bus_request(o_bus_request),
    .o_bus_rw     (o_bus_rw),
    .o_bus_address(o_bus_address),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_ready  (i_bus_ready),
    .i_bus_rdata  (i_bus_rdata),
    .o_grant      (o_grant),
    .o_contention (o_contention)
  );

  // 10-unit clock
  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's drive point.
  task automatic step();
    @(posedge i_clock);
    #2;
  endtask

  // Let combinational outputs settle after driving.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    i_reset     = 1'b1;
    i_i_request = 1'b0;
    i_i_rw      = 1'b0;
    i_i_address = 32'h0000_0000;
    i_i_wdata   = 32'h0000_0000;
    i_d_request = 1'b0;
    i_d_rw      = 1'b0;
    i_d_address = 32'h0000_0000;
    i_d_wdata   = 32'h0000_0000;
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'h0000_0000;

    // ---- reset state ----
    do_reset();
    settle();
    check_val("rst_grant",   {30'd0, o_grant}, 32'h0);
    check_val("rst_busreq",  {31'd0, o_bus_request}, 32'h0);
    check_val("rst_busaddr", o_bus_address, 32'h0);
    check_val("rst_cnt",     o_contention, 32'h0);
    check_val("rst_rdy",     {30'd0, o_i_ready, o_d_ready}, 32'h0);

    // ---- single D read ----
    i_d_request = 1'b1;
    i_d_rw      = 1'b0;
    i_d_address = 32'h0000_1000;
    settle();
    check_val("t1_c0_busreq", {31'd0, o_bus_request}, 32'h0);
    step(); settle();
    check_val("t1_c1_busreq", {31'd0, o_bus_request}, 32'h1);
    check_val("t1_c1_addr",   o_bus_address, 32'h0000_1000);
    check_val("t1_c1_rw",     {31'd0, o_bus_rw}, 32'h0);
    check_val("t1_c1_grant",  {30'd0, o_grant}, 32'h2);
    step(); settle();
    check_val("t1_c2_drdy",   {31'd0, o_d_ready}, 32'h0);
    step();
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'hDEAD_BEEF;
    settle();
    check_val("t1_c3_drdy",   {31'd0, o_d_ready}, 32'h1);
    check_val("t1_c3_drdata", o_d_rdata, 32'hDEAD_BEEF);
    check_val("t1_c3_irdy",   {31'd0, o_i_ready}, 32'h0);
    check_val("t1_c3_irdata", o_i_rdata, 32'h0);
    step();
    i_bus_ready = 1'b0;
    i_d_request = 1'b0;
    settle();
    check_val("t1_c4_grant",  {30'd0, o_grant}, 32'h0);
    check_val("t1_c4_busreq", {31'd0, o_bus_request}, 32'h0);
    check_val("t1_c4_cnt",    o_contention, 32'h0);

    // ---- simultaneous requests after reset ----
    do_reset();
    i_i_request = 1'b1;
    i_i_address = 32'h0000_0100;
    i_d_request = 1'b1;
    i_d_address = 32'h0000_0200;
    step(); settle();
    check_val("t2_grant_i", {30'd0, o_grant}, 32'h1);
    check_val("t2_cnt1",    o_contention, 32'h1);
    check_val("t2_addr_i",  o_bus_address, 32'h0000_0100);
    step();
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'h0000_0011;
    settle();
    check_val("t2_irdy",   {31'd0, o_i_ready}, 32'h1);
    check_val("t2_irdata", o_i_rdata, 32'h0000_0011);
    check_val("t2_drdy",   {31'd0, o_d_ready}, 32'h0);
    step();
    i_bus_ready = 1'b0;
    i_i_request = 1'b0;
    settle();
    check_val("t2_bubble", {30'd0, o_grant}, 32'h0);
    step(); settle();
    check_val("t2_grant_d", {30'd0, o_grant}, 32'h2);
    check_val("t2_addr_d",  o_bus_address, 32'h0000_0200);
    check_val("t2_cnt_hold", o_contention, 32'h1);
    step();
    i_bus_ready = 1'b1;
    settle();
    check_val("t2_drdy2", {31'd0, o_d_ready}, 32'h1);
    step();
    i_bus_ready = 1'b0;
    i_d_request = 1'b0;

    // ---- sustained contention, 4 transactions ----
    do_reset();
    i_i_request = 1'b1;
    i_d_request = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(); settle();
      check_val($sformatf("t3_grant%0d", k), {30'd0, o_grant},
                ((k % 2) == 0) ? 32'h1 : 32'h2);
      check_val($sformatf("t3_cnt%0d", k), o_contention, k + 1);
      i_bus_ready = 1'b1;
      settle();
      check_val($sformatf("t3_nboth%0d", k), {31'd0, o_i_ready & o_d_ready}, 32'h0);
      step();
      i_bus_ready = 1'b0;
      if (k == 3) begin
        i_i_request = 1'b0;
        i_d_request = 1'b0;
      end
      settle();
      check_val($sformatf("t3_idle%0d", k), {30'd0, o_grant}, 32'h0);
    end
    step(); settle();
    check_val("t3_cnt_final", o_contention, 32'h4);
    check_val("t3_end_grant", {30'd0, o_grant}, 32'h0);

    // ---- D write while I requests ----
    do_reset();
    i_d_request = 1'b1;
    i_d_rw      = 1'b1;
    i_d_address = 32'h0000_2004;
    i_d_wdata   = 32'h1234_5678;
    step();
    i_i_request = 1'b1;
    i_i_rw      = 1'b0;
    i_i_address = 32'h0000_0300;
    settle();
    check_val("t4_grant_d", {30'd0, o_grant}, 32'h2);
    check_val("t4_rw",      {31'd0, o_bus_rw}, 32'h1);
    check_val("t4_addr",    o_bus_address, 32'h0000_2004);
    check_val("t4_wdata",   o_bus_wdata, 32'h1234_5678);
    step();
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'h0000_0055;
    settle();
    check_val("t4_drdy", {31'd0, o_d_ready}, 32'h1);
    check_val("t4_irdy", {31'd0, o_i_ready}, 32'h0);
    step();
    i_bus_ready = 1'b0;
    i_d_request = 1'b0;
    settle();
    check_val("t4_bubble", {30'd0, o_grant}, 32'h0);
    step(); settle();
    check_val("t4_grant_i", {30'd0, o_grant}, 32'h1);
    check_val("t4_addr_i",  o_bus_address, 32'h0000_0300);
    check_val("t4_rw_i",    {31'd0, o_bus_rw}, 32'h0);
    check_val("t4_cnt",     o_contention, 32'h0);
    i_bus_ready = 1'b1;
    settle();
    check_val("t4_irdy2", {31'd0, o_i_ready}, 32'h1);
    step();
    i_bus_ready = 1'b0;
    i_i_request = 1'b0;

    // ---- abort on I keeps last_grant = D ----
    do_reset();
    i_i_request = 1'b1;
    i_i_address = 32'h0000_0400;
    step(); settle();
    check_val("t5_grant_i", {30'd0, o_grant}, 32'h1);
    i_i_request = 1'b0;
    settle();
    check_val("t5_irdy_abort", {31'd0, o_i_ready}, 32'h0);
    step(); settle();
    check_val("t5_idle", {30'd0, o_grant}, 32'h0);
    i_i_request = 1'b1;
    i_d_request = 1'b1;
    step(); settle();
    check_val("t5_tie_i", {30'd0, o_grant}, 32'h1);
    check_val("t5_cnt",   o_contention, 32'h1);
    i_i_request = 1'b0;
    i_d_request = 1'b0;
    step();

    // ---- reset mid-grant, then stray bus ready ----
    do_reset();
    i_d_request = 1'b1;
    i_d_address = 32'h0000_0500;
    i_i_request = 1'b1;
    i_i_address = 32'h0000_0600;
    step(); settle();
    check_val("t6_pre_grant", {30'd0, o_grant}, 32'h1);
    check_val("t6_pre_cnt",   o_contention, 32'h1);
    i_reset = 1'b1;
    step();
    i_reset     = 1'b0;
    i_i_request = 1'b0;
    i_d_request = 1'b0;
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'hCAFE_F00D;
    settle();
    check_val("t6_irdy",   {31'd0, o_i_ready}, 32'h0);
    check_val("t6_drdy",   {31'd0, o_d_ready}, 32'h0);
    check_val("t6_irdata", o_i_rdata, 32'h0);
    check_val("t6_busreq", {31'd0, o_bus_request}, 32'h0);
    check_val("t6_cnt",    o_contention, 32'h0);
    check_val("t6_grant",  {30'd0, o_grant}, 32'h0);
    step();
    i_bus_ready = 1'b0;
    settle();
    check_val("t6_still_idle", {30'd0, o_grant}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Shares the single CPU system-bus master port between two requesters: the instruction-fetch path (port I) and the data-cache path (port D).
- Sits between the fetch/ICache and memory-stage/DCache bus outputs and the external bus.
- Grants exactly one requester per transaction, with round-robin fairness under contention.
- Keeps a contention counter for performance monitoring.

Parameters:
- ADDR_W, 32, width of the bus address.
- DATA_W, 32, width of the read and write data.
- CNT_W, 32, width of the contention counter.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_i_request  in  1  port I request; held until i_ready is seen.
- i_i_rw  in  1  port I direction (1 = write).
- i_i_address  in  ADDR_W  port I word address.
- i_i_wdata  in  DATA_W  port I write data.
- o_i_ready  out  1  port I transfer-complete strobe.
- o_i_rdata  out  DATA_W  port I read data; valid while o_i_ready.
- i_d_request, i_d_rw, i_d_address, i_d_wdata, o_d_ready, o_d_rdata: same as port I, for port D.
- o_bus_request  out  1  bus request.
- o_bus_rw  out  1  bus direction.
- o_bus_address  out  ADDR_W  bus address.
- o_bus_wdata  out  DATA_W  bus write data.
- i_bus_ready  in  1  bus transfer complete; single-cycle strobe.
- i_bus_rdata  in  DATA_W  bus read data; valid with i_bus_ready.
- o_grant  out  2  one-hot current grant: bit0 = I, bit1 = D.
- o_contention  out  CNT_W  count of arbitration cycles in which both ports requested.

Behaviour:
- Reset values: state IDLE, last_grant = D (so port I wins the first tie), o_grant = 0, o_bus_request = 0, o_bus_rw = 0, o_bus_address = 0, o_bus_wdata = 0, o_i_ready = o_d_ready = 0, o_contention = 0.
- FSM states: IDLE, GRANT_I, GRANT_D. State, last_grant and the counter are registered. Bus and ready outputs are combinational from the state.
- IDLE:
  - o_bus_request = 0; all bus outputs are 0.
  - Only I requests -> GRANT_I.
  - Only D requests -> GRANT_D.
  - Both request -> grant the port not equal to last_grant, and increment o_contention (saturating at all-ones).
  - Neither requests -> stay in IDLE.
- GRANT_x:
  - Bus rw/address/wdata/request are driven combinationally from port x.
  - o_x_ready = i_bus_ready; o_x_rdata = i_bus_rdata.
  - The other port sees ready = 0 and rdata = 0.
- Leaving GRANT_x:
  - On i_bus_ready: last_grant <= x, next state IDLE.
  - If i_x_request drops without i_bus_ready (abort): next state IDLE, last_grant unchanged.
- Latency:
  - Request in IDLE at cycle N -> o_bus_request at N+1.
  - Ready strobe passes through with 0 added latency.
  - One mandatory IDLE bubble between back-to-back transactions; a re-request in that bubble is arbitrated normally.
- A requester asserting in IDLE while the other is mid-transaction sees no effect until the grant ends; there is no preemption.
- i_bus_ready while in IDLE is ignored: no ready to either port, no state change.
- Request changes during a grant: address/rw/wdata changes on the granted port pass straight through (requesters hold them stable by protocol). Non-granted port inputs are ignored.
- Reset mid-transaction: at the reset edge, state becomes IDLE and the grant clears. The bus request deasserts from the next cycle. A later i_bus_ready is ignored.
- o_grant is one-hot or zero; it never has both bits set.

Test Plan:
- Single read on D, no contention: i_d_request=1, address 0x0000_1000, rw=0 at cycle 0 -> o_bus_request=1 with address 0x1000 at cycle 1. Bus ready at cycle 3 with rdata 0xDEADBEEF -> o_d_ready=1 and o_d_rdata=0xDEADBEEF at cycle 3, o_i_ready=0, state IDLE at cycle 4.
- Simultaneous requests after reset: I and D both assert -> I granted first, o_contention=1. After I's ready, D (still requesting) is granted after one IDLE cycle, o_contention stays 1.
- Sustained contention for 4 transactions -> grant order I, D, I, D; o_contention=4; o_grant never 2'b11.
- D write 0x1234_5678 to 0x2004 while I requests -> bus rw=1, address 0x2004, wdata 0x12345678. I sees no ready until its own grant.
- Abort: I granted, i_i_request drops before ready -> IDLE next cycle, last_grant stays D. A following tie then grants I again.
- Reset mid-grant, then i_bus_ready -> no ready on either port, o_bus_request=0, o_contention=0.
